// File: rtl/cu_pkg.sv
// Shared constants for the hardwired control unit: opcodes, ALU codes,
// sequencer state encodings and the instruction-class type.
package cu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD   = 5'b00011;
    localparam logic [4:0] ALU_INCPC = 5'b11111;

    localparam logic [3:0] S_T0   = 4'd0;
    localparam logic [3:0] S_T1   = 4'd1;
    localparam logic [3:0] S_T2   = 4'd2;
    localparam logic [3:0] S_T3   = 4'd3;
    localparam logic [3:0] S_T4   = 4'd4;
    localparam logic [3:0] S_T5   = 4'd5;
    localparam logic [3:0] S_T6   = 4'd6;
    localparam logic [3:0] S_T7   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    typedef enum logic [3:0] {
        C_RALU, C_IMM, C_MULDIV, C_UNARY,
        C_LDI, C_LD, C_ST, C_BR,
        C_JR, C_JAL, C_IN, C_OUT,
        C_MFHI, C_MFLO, C_NOP, C_HALT
    } cls_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode to instruction-class decode; the sequencer only sees the class.
// Unassigned opcodes fall into the nop class.
module cu_decode
    import cu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] op_i,
    output cls_t           cls_o
);

    // Classify the opcode
    always_comb begin
        cls_o = C_NOP;
        unique case (op_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls_o = C_RALU;
            OP_ADDI, OP_ANDI, OP_ORI:      cls_o = C_IMM;
            OP_MUL, OP_DIV:                cls_o = C_MULDIV;
            OP_NEG, OP_NOT:                cls_o = C_UNARY;
            OP_LDI:                        cls_o = C_LDI;
            OP_LD:                         cls_o = C_LD;
            OP_ST:                         cls_o = C_ST;
            OP_BR:                         cls_o = C_BR;
            OP_JR:                         cls_o = C_JR;
            OP_JAL:                        cls_o = C_JAL;
            OP_IN:                         cls_o = C_IN;
            OP_OUT:                        cls_o = C_OUT;
            OP_MFHI:                       cls_o = C_MFHI;
            OP_MFLO:                       cls_o = C_MFLO;
            OP_HALT:                       cls_o = C_HALT;
            default:                       cls_o = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer driving DataPath strobes from IR[31:27].
// Optional macro CU_MEM_WAIT_EN adds mem_ready handshaking on memory states.
module control_unit
    import cu_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 5
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     IR,
    input  logic            ConOut,
`ifdef CU_MEM_WAIT_EN
    input  logic            mem_ready,
`endif
    output logic            HiIn,
    output logic            LoIn,
    output logic            ZIn,
    output logic            PCIn,
    output logic            MDRIn,
    output logic            MARIn,
    output logic            YIn,
    output logic            OPortIn,
    output logic            IRIn,
    output logic            HiOut,
    output logic            LoOut,
    output logic            ZHiOut,
    output logic            ZLoOut,
    output logic            PCOut,
    output logic            MDROut,
    output logic            IPortOut,
    output logic            COut,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            RIn,
    output logic            ROut,
    output logic            BAOut,
    output logic            Conin,
    output logic            memread,
    output logic            memwrite,
    output logic [ALUW-1:0] ALUCode,
    output logic            run
);

    logic [3:0]     state_q;
    logic [3:0]     state_d;
    logic [OPW-1:0] op;
    cls_t           cls;
    logic           mem_rdy;
    logic           unused_ir;

    assign op        = IR[31 -: OPW];
    assign unused_ir = ^IR[31-OPW:0];

`ifdef CU_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    cu_decode #(.OPW(OPW)) u_dec (
        .op_i  (op),
        .cls_o (cls)
    );

    // State advances on the falling edge so strobes are settled by the rising edge
    always_ff @(negedge clock or negedge clear) begin
        if (!clear) state_q <= S_T0;
        else        state_q <= state_d;
    end

    // Next-state: fetch, then class-dependent execute length, then back to T0
    always_comb begin
        state_d = S_T0;
        unique case (state_q)
            S_T0: state_d = S_T1;
            S_T1: state_d = mem_rdy ? S_T2 : S_T1;
            S_T2: begin
                unique case (cls)
                    C_NOP:   state_d = S_T0;
                    C_HALT:  state_d = S_HALT;
                    default: state_d = S_T3;
                endcase
            end
            S_T3: begin
                unique case (cls)
                    C_JR, C_IN, C_OUT,
                    C_MFHI, C_MFLO: state_d = S_T0;
                    default:        state_d = S_T4;
                endcase
            end
            S_T4: begin
                unique case (cls)
                    C_UNARY, C_JAL: state_d = S_T0;
                    default:        state_d = S_T5;
                endcase
            end
            S_T5: begin
                unique case (cls)
                    C_RALU, C_IMM, C_LDI: state_d = S_T0;
                    default:              state_d = S_T6;
                endcase
            end
            S_T6: begin
                unique case (cls)
                    C_LD:    state_d = mem_rdy ? S_T7 : S_T6;
                    C_ST:    state_d = mem_rdy ? S_T0 : S_T6;
                    default: state_d = S_T0;
                endcase
            end
            S_T7:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_T0;
        endcase
    end

    // Strobe decode from state and class; everything forced low during clear
    always_comb begin
        HiIn = 1'b0; LoIn = 1'b0; ZIn = 1'b0; PCIn = 1'b0;
        MDRIn = 1'b0; MARIn = 1'b0; YIn = 1'b0; OPortIn = 1'b0;
        IRIn = 1'b0; HiOut = 1'b0; LoOut = 1'b0; ZHiOut = 1'b0;
        ZLoOut = 1'b0; PCOut = 1'b0; MDROut = 1'b0; IPortOut = 1'b0;
        COut = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        RIn = 1'b0; ROut = 1'b0; BAOut = 1'b0; Conin = 1'b0;
        memread = 1'b0; memwrite = 1'b0;
        ALUCode = '0;
        run = clear && (state_q != S_HALT);
        if (clear) begin
            unique case (state_q)
                S_T0: begin
                    PCOut = 1'b1; MARIn = 1'b1; ZIn = 1'b1;
                    ALUCode = ALUW'(ALU_INCPC);
                end
                S_T1: begin
                    ZLoOut = 1'b1; PCIn = 1'b1;
                    memread = 1'b1; MDRIn = 1'b1;
                end
                S_T2: begin
                    MDROut = 1'b1; IRIn = 1'b1;
                end
                S_T3: begin
                    unique case (cls)
                        C_RALU, C_IMM: begin
                            Grb = 1'b1; ROut = 1'b1; YIn = 1'b1;
                        end
                        C_MULDIV: begin
                            Gra = 1'b1; ROut = 1'b1; YIn = 1'b1;
                        end
                        C_UNARY: begin
                            Grb = 1'b1; ROut = 1'b1; ZIn = 1'b1;
                            ALUCode = ALUW'(op);
                        end
                        C_LDI, C_LD, C_ST: begin
                            Grb = 1'b1; BAOut = 1'b1; YIn = 1'b1;
                        end
                        C_BR: begin
                            Gra = 1'b1; ROut = 1'b1; Conin = 1'b1;
                        end
                        C_JR: begin
                            Gra = 1'b1; ROut = 1'b1; PCIn = 1'b1;
                        end
                        C_JAL: begin
                            PCOut = 1'b1; Grb = 1'b1; RIn = 1'b1;
                        end
                        C_IN: begin
                            IPortOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
                        end
                        C_OUT: begin
                            Gra = 1'b1; ROut = 1'b1; OPortIn = 1'b1;
                        end
                        C_MFHI: begin
                            HiOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
                        end
                        C_MFLO: begin
                            LoOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T4: begin
                    unique case (cls)
                        C_RALU: begin
                            Grc = 1'b1; ROut = 1'b1; ZIn = 1'b1;
                            ALUCode = ALUW'(op);
                        end
                        C_IMM: begin
                            COut = 1'b1; ZIn = 1'b1;
                            ALUCode = ALUW'(op);
                        end
                        C_MULDIV: begin
                            Grb = 1'b1; ROut = 1'b1; ZIn = 1'b1;
                            ALUCode = ALUW'(op);
                        end
                        C_UNARY: begin
                            ZLoOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
                        end
                        C_LDI, C_LD, C_ST: begin
                            COut = 1'b1; ZIn = 1'b1;
                            ALUCode = ALUW'(ALU_ADD);
                        end
                        C_BR: begin
                            PCOut = 1'b1; YIn = 1'b1;
                        end
                        C_JAL: begin
                            Gra = 1'b1; ROut = 1'b1; PCIn = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    unique case (cls)
                        C_RALU, C_IMM, C_LDI: begin
                            ZLoOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
                        end
                        C_MULDIV: begin
                            ZLoOut = 1'b1; LoIn = 1'b1;
                        end
                        C_LD, C_ST: begin
                            ZLoOut = 1'b1; MARIn = 1'b1;
                        end
                        C_BR: begin
                            COut = 1'b1; ZIn = 1'b1;
                            ALUCode = ALUW'(ALU_ADD);
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    unique case (cls)
                        C_MULDIV: begin
                            ZHiOut = 1'b1; HiIn = 1'b1;
                        end
                        C_LD: begin
                            memread = 1'b1; MDRIn = 1'b1;
                        end
                        C_ST: begin
                            memwrite = 1'b1; Gra = 1'b1; ROut = 1'b1;
                        end
                        C_BR: begin
                            ZLoOut = 1'b1; PCIn = ConOut;
                        end
                        default: ;
                    endcase
                end
                S_T7: begin
                    if (cls == C_LD) begin
                        MDROut = 1'b1; Gra = 1'b1; RIn = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
